// File: rtl/des_result_collector.sv
// Result collector for a des_block array: starts all blocks, waits for every done, sums the
// per-block counters over a valid/ready stream. Optional `PER_BLOCK_DUMP_EN streams each counter first.
module des_result_collector #(
    parameter int NUM_BLOCKS = 4,
    parameter int N          = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_start,
    input  logic                         cmd_abort,
    input  logic [NUM_BLOCKS-1:0]        block_done,
    input  logic [NUM_BLOCKS*(64-N)-1:0] block_counter,
    output logic                         start_blocks,
    output logic                         restart_blocks,
    output logic [63:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);

    localparam int CW    = 64 - N;
    localparam int SUM_W = CW + $clog2(NUM_BLOCKS);
    localparam int IW    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ACCUM,
        S_EMIT,
        S_RESTART
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [SUM_W-1:0] acc;
    logic [CW-1:0]    cur_cnt;
    logic [63:0]      sum_word;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_cnt  = block_counter[idx*CW +: CW];
        sum_word = '0;
        sum_word[SUM_W-1:0] = acc;
    end

`ifdef PER_BLOCK_DUMP_EN
    localparam int WW = $clog2(NUM_BLOCKS + 1);

    logic [CW-1:0] dump_q [NUM_BLOCKS];
    logic [WW-1:0] widx;
    logic [IW-1:0] nidx;
    logic [63:0]   first_word;
    logic [63:0]   next_word;

    // NOTE: the dump registers carry no reset; ACCUM always rewrites them before EMIT reads them.
    always_ff @(posedge clk) begin
        if (state == S_ACCUM) begin
            dump_q[idx] <= cur_cnt;
        end
    end

    always_comb begin
        nidx       = IW'(widx + WW'(1));
        first_word = '0;
        first_word[CW-1:0] = dump_q[0];
        next_word  = sum_word;
        if (int'(widx) < NUM_BLOCKS - 1) begin
            next_word = '0;
            next_word[CW-1:0] = dump_q[nidx];
        end
    end
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            acc            <= '0;
            start_blocks   <= 1'b0;
            restart_blocks <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
`ifdef PER_BLOCK_DUMP_EN
            widx           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state        <= S_RUN;
                        start_blocks <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                // start_blocks is high only in the first RUN cycle, which must ignore stale done bits
                S_RUN: begin
                    start_blocks <= 1'b0;
                    if (cmd_abort) begin
                        state          <= S_RESTART;
                        restart_blocks <= 1'b1;
                    end else if (!start_blocks && (&block_done)) begin
                        state <= S_ACCUM;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end

                S_ACCUM: begin
                    if (cmd_abort) begin
                        state          <= S_RESTART;
                        restart_blocks <= 1'b1;
                    end else begin
                        acc <= acc + SUM_W'(cur_cnt);
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= S_EMIT;
                        end
                    end
                end

                S_EMIT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
`ifdef PER_BLOCK_DUMP_EN
                        out_data  <= first_word;
                        out_last  <= 1'b0;
                        widx      <= '0;
`else
                        out_data  <= sum_word;
                        out_last  <= 1'b1;
`endif
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid      <= 1'b0;
                            out_last       <= 1'b0;
                            state          <= S_RESTART;
                            restart_blocks <= 1'b1;
                        end
`ifdef PER_BLOCK_DUMP_EN
                        else begin
                            out_data <= next_word;
                            out_last <= (int'(widx) == NUM_BLOCKS - 1);
                            widx     <= widx + 1'b1;
                        end
`endif
                    end
                end

                S_RESTART: begin
                    restart_blocks <= 1'b0;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
